crc_serial_engine: RTL

//  Parametrised bit-serial CRC engine for the tag datapath; generalises the fixed CRC5 checker to any width/polynomial.

---
 rtl/crc_serial_engine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - parametrised bit-serial CRC engine with check and generate modes
module crc_serial_engine #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h1021,
    parameter logic [WIDTH-1:0] PRESET     = 16'hFFFF,
    parameter logic [WIDTH-1:0] RESIDUE    = 16'h1D0F,
    parameter bit               INVERT_OUT = 1'b1,
    parameter int               CNTW       = 10
) (
    input  logic             crcinclk,
    input  logic             reset,
    input  logic             start,
    input  logic             genmode,
    input  logic             bitvalid,
    input  logic             crcbitin,
    input  logic             frameend,
    input  logic             outready,
    output logic [WIDTH-1:0] crc,
    output logic [CNTW-1:0]  bitcount,
    output logic             overflow,
    output logic             busy,
    output logic             crcbitout,
    output logic             bitoutvalid,
    output logic             done,
    output logic             crcok
);
    localparam int IDXW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SHIFTOUT, S_DONE} state_t;

    state_t           state, state_nx;
    logic             gen_q;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] sreg;
    logic             fb;
    logic [WIDTH-1:0] crc_upd, crc_nx;
    logic [CNTW-1:0]  cnt_nx;
    logic             ovf_nx, ok_nx, accept, last_out;

    // sreg holds the outgoing word and shifts left, so it reads zero once emptied
    assign crcbitout = sreg[WIDTH-1];

    always_comb begin
        fb       = crcbitin ^ crc[WIDTH-1];
        crc_upd  = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        crc_nx   = crc;
        cnt_nx   = bitcount;
        ovf_nx   = overflow;
        if (state == S_ACCUM && bitvalid) begin
            crc_nx = crc_upd;
            if (bitcount == '1) ovf_nx = 1'b1;
            else                cnt_nx = bitcount + 1'b1;
        end
        ok_nx    = (crc_nx == RESIDUE) && (int'(cnt_nx) >= WIDTH) && !ovf_nx;
        accept   = bitoutvalid && outready;
        last_out = (idx == IDXW'(WIDTH - 1));
        state_nx = state;
        case (state)
            S_ACCUM:    if (frameend) state_nx = gen_q ? S_SHIFTOUT : S_DONE;
            S_SHIFTOUT: if (accept && last_out) state_nx = S_DONE;
            default:    state_nx = state;
        endcase
        if (start) state_nx = S_ACCUM;
    end

    always_ff @(posedge crcinclk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            busy        <= (state_nx == S_ACCUM) || (state_nx == S_SHIFTOUT);
        end
    end

    always_ff @(posedge crcinclk) begin
        if (reset) begin
            crc         <= PRESET;
            bitcount    <= '0;
            overflow    <= 1'b0;
            bitoutvalid <= 1'b0;
            done        <= 1'b0;
            crcok       <= 1'b0;
            idx         <= '0;
            sreg        <= '0;
            gen_q       <= 1'b0;
        end else if (start) begin
            crc         <= PRESET;
            bitcount    <= '0;
            overflow    <= 1'b0;
            bitoutvalid <= 1'b0;
            done        <= 1'b0;
            crcok       <= 1'b0;
            idx         <= '0;
            sreg        <= '0;
            gen_q       <= genmode;
        end else begin
            case (state)
                S_ACCUM: begin
                    crc      <= crc_nx;
                    bitcount <= cnt_nx;
                    overflow <= ovf_nx;
                    if (frameend) begin
                        if (gen_q) begin
                            bitoutvalid <= 1'b1;
                            idx         <= '0;
                            sreg        <= INVERT_OUT ? ~crc_nx : crc_nx;
                        end else begin
                            done  <= 1'b1;
                            crcok <= ok_nx;
                        end
                    end
                end
                S_SHIFTOUT: begin
                    if (accept) begin
                        sreg <= {sreg[WIDTH-2:0], 1'b0};
                        if (last_out) begin
                            bitoutvalid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
